// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lock_sequencer
// Description : Control FSM for a 4-digit hex combination lock. Conditions
//               three raw push-buttons into single-cycle events, captures a
//               password, checks unlock attempts against it and enforces a
//               timed lockout after repeated wrong attempts.
// Ports       : clock          - system clock, rising edge
//               reset          - asynchronous active-low reset
//               digit_in[3:0]  - hex digit from switches, sampled on enter
//               enter_button   - raw button level (asynchronous)
//               set_button     - raw button level (asynchronous)
//               change_button  - raw button level (asynchronous)
//               hex1..hex4     - entered digits, first to fourth
//               counter[1:0]   - slot of the next digit, holds 3 when full
//               entry_full     - all four digits entered
//               state[1:0]     - 00 INITIAL, 01 UNLOCKED, 10 LOCKED, 11 LOCKOUT
//               unlocked       - high while UNLOCKED
//               lockout        - high while LOCKOUT
// Revision    : 1.0 - initial release
// ============================================================================
module lock_sequencer #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 500000000,
  parameter int CNT_W          = 29
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       enter_button,
  input  logic       set_button,
  input  logic       change_button,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex4,
  output logic [1:0] counter,
  output logic       entry_full,
  output logic [1:0] state,
  output logic       unlocked,
  output logic       lockout
);

  typedef enum logic [1:0] {
    ST_INITIAL  = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_LOCKOUT  = 2'b11
  } state_t;

  localparam logic [3:0]       c_MAX_FAILS  = 4'(MAX_FAILS);
  localparam logic [CNT_W-1:0] c_LOCK_START = CNT_W'(LOCKOUT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Button conditioning. Bit 0 = enter, bit 1 = set, bit 2 = change.
  // --------------------------------------------------------------------------
  logic [2:0] w_btn;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_prev;
  logic [2:0] r_armed;
  logic [1:0] r_warm;
  logic [2:0] w_ev;

  assign w_btn = {change_button, set_button, enter_button};

  // A button is only armed once the synchroniser has shown it low after
  // reset. r_warm waits until r_sync2 carries a real sample, so a button held
  // through reset release never produces an event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_armed <= '0;
      r_warm  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_warm != 2'd2) begin
        r_warm <= r_warm + 2'd1;
      end else begin
        r_armed <= r_armed | ~r_sync2;
      end
    end
  end

  assign w_ev = r_sync2 & ~r_prev & r_armed;

  // change > set > enter; losers in the same cycle are dropped.
  logic w_chg;
  logic w_set;
  logic w_ent;

  assign w_chg = w_ev[2];
  assign w_set = w_ev[1] & ~w_ev[2];
  assign w_ent = w_ev[0] & ~w_ev[1] & ~w_ev[2];

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  state_t           r_state,     w_state_nxt;
  logic [3:0][3:0]  r_buf,       w_buf_nxt;    // r_buf[0] is hex1
  logic [1:0]       r_counter,   w_counter_nxt;
  logic             r_full,      w_full_nxt;
  logic [15:0]      r_pwd,       w_pwd_nxt;
  logic [3:0]       r_fails,     w_fails_nxt;
  logic [CNT_W-1:0] r_lock_cnt,  w_lock_cnt_nxt;
  logic             r_unlocked;
  logic             r_lockout;

  logic [15:0] w_entry;
  logic [3:0]  w_fails_inc;

  assign w_entry     = {r_buf[0], r_buf[1], r_buf[2], r_buf[3]};
  assign w_fails_inc = r_fails + 4'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INITIAL;
      r_buf      <= '0;
      r_counter  <= '0;
      r_full     <= 1'b0;
      r_pwd      <= '0;
      r_fails    <= '0;
      r_lock_cnt <= '0;
      r_unlocked <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_counter  <= w_counter_nxt;
      r_full     <= w_full_nxt;
      r_pwd      <= w_pwd_nxt;
      r_fails    <= w_fails_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      // Status flags are decoded from the next state so they move with state.
      r_unlocked <= (w_state_nxt == ST_UNLOCKED);
      r_lockout  <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_buf_nxt      = r_buf;
    w_counter_nxt  = r_counter;
    w_full_nxt     = r_full;
    w_pwd_nxt      = r_pwd;
    w_fails_nxt    = r_fails;
    w_lock_cnt_nxt = r_lock_cnt;

    case (r_state)
      ST_INITIAL, ST_LOCKED: begin
        if (w_chg) begin
          w_buf_nxt     = '0;
          w_counter_nxt = '0;
          w_full_nxt    = 1'b0;
        end else if (w_set) begin
          if (r_full) begin
            w_buf_nxt     = '0;
            w_counter_nxt = '0;
            w_full_nxt    = 1'b0;
            if (r_state == ST_INITIAL) begin
              w_pwd_nxt   = w_entry;
              w_fails_nxt = '0;
              w_state_nxt = ST_LOCKED;
            end else if (w_entry == r_pwd) begin
              w_fails_nxt = '0;
              w_state_nxt = ST_UNLOCKED;
            end else begin
              w_fails_nxt = w_fails_inc;
              if (w_fails_inc == c_MAX_FAILS) begin
                w_lock_cnt_nxt = c_LOCK_START;
                w_state_nxt    = ST_LOCKOUT;
              end
            end
          end
        end else if (w_ent && !r_full) begin
          w_buf_nxt[r_counter] = digit_in;
          if (r_counter == 2'd3) begin
            w_full_nxt = 1'b1;
          end else begin
            w_counter_nxt = r_counter + 2'd1;
          end
        end
      end

      ST_UNLOCKED: begin
        w_buf_nxt     = '0;
        w_counter_nxt = '0;
        w_full_nxt    = 1'b0;
        if (w_chg) begin
          w_state_nxt = ST_INITIAL;
        end else if (w_set) begin
          w_state_nxt = ST_LOCKED;
        end
      end

      default: begin // ST_LOCKOUT
        w_buf_nxt     = '0;
        w_counter_nxt = '0;
        w_full_nxt    = 1'b0;
        if (r_lock_cnt == '0) begin
          w_fails_nxt = '0;
          w_state_nxt = ST_LOCKED;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - 1'b1;
        end
      end
    endcase
  end

  assign hex1       = r_buf[0];
  assign hex2       = r_buf[1];
  assign hex3       = r_buf[2];
  assign hex4       = r_buf[3];
  assign counter    = r_counter;
  assign entry_full = r_full;
  assign state      = r_state;
  assign unlocked   = r_unlocked;
  assign lockout    = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_sequencer
// Description : Directed self-checking bench for lock_sequencer with a short
//               lockout (20 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit_in = 4'h0;
  logic       enter_button = 1'b0;
  logic       set_button = 1'b0;
  logic       change_button = 1'b0;
  logic [3:0] hex1, hex2, hex3, hex4;
  logic [1:0] counter;
  logic       entry_full;
  logic [1:0] state;
  logic       unlocked;
  logic       lockout;

  int vectors     = 0;
  int miscompares = 0;

  lock_sequencer #(
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (20),
    .CNT_W          (5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .digit_in      (digit_in),
    .enter_button  (enter_button),
    .set_button    (set_button),
    .change_button (change_button),
    .hex1          (hex1),
    .hex2          (hex2),
    .hex3          (hex3),
    .hex4          (hex4),
    .counter       (counter),
    .entry_full    (entry_full),
    .state         (state),
    .unlocked      (unlocked),
    .lockout       (lockout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the chosen buttons high for 'hold' cycles, then let the event settle.
  task automatic press(input logic e, input logic s, input logic c,
                       input logic [3:0] d, input int hold);
    digit_in = d;
    @(posedge clock); #1;
    enter_button  = e;
    set_button    = s;
    change_button = c;
    repeat (hold) @(posedge clock);
    #1;
    enter_button  = 1'b0;
    set_button    = 1'b0;
    change_button = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 1'b0, code[15-4*i -: 4], 1);
    end
  endtask

  task automatic check_idle_buf(input string tag);
    check({tag, "_hex"}, {16'h0, hex1, hex2, hex3, hex4}, 32'h0);
    check({tag, "_cnt"}, {30'h0, counter}, 32'd0);
    check({tag, "_full"}, {31'h0, entry_full}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clock);
    #1;
    check("rst_state", {30'h0, state}, 32'd0);
    check_idle_buf("rst");
    check("rst_unlocked", {31'h0, unlocked}, 32'd0);
    check("rst_lockout", {31'h0, lockout}, 32'd0);
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    // ---------------- first digit: latency and long hold ----------------
    digit_in = 4'h1;
    @(posedge clock); #1;
    enter_button = 1'b1;          // first sampled at edge k
    @(posedge clock);             // edge k
    @(posedge clock); #1;         // edge k+1
    check("lat_k1_cnt", {30'h0, counter}, 32'd0);
    @(posedge clock); #1;         // edge k+2
    check("lat_k2_cnt", {30'h0, counter}, 32'd1);
    check("lat_k2_hex1", {28'h0, hex1}, 32'h1);
    repeat (47) @(posedge clock);
    #1;
    enter_button = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("hold50_cnt", {30'h0, counter}, 32'd1);

    press(1'b1, 1'b0, 1'b0, 4'h2, 1);
    check("cnt2", {30'h0, counter}, 32'd2);
    press(1'b1, 1'b0, 1'b0, 4'h3, 1);
    check("cnt3", {30'h0, counter}, 32'd3);
    check("full_before4", {31'h0, entry_full}, 32'd0);
    press(1'b1, 1'b0, 1'b0, 4'h4, 1);
    check("cnt_full", {30'h0, counter}, 32'd3);
    check("full_after4", {31'h0, entry_full}, 32'd1);
    check("buf_1234", {16'h0, hex1, hex2, hex3, hex4}, 32'h1234);

    // 5th enter while full is ignored
    press(1'b1, 1'b0, 1'b0, 4'h9, 1);
    check("fifth_enter", {16'h0, hex1, hex2, hex3, hex4}, 32'h1234);

    // ---------------- set password ----------------
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("setpw_state", {30'h0, state}, 32'd2);
    check_idle_buf("setpw");

    // ---------------- correct unlock ----------------
    enter_code(16'h1234);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("unlock_state", {30'h0, state}, 32'd1);
    check("unlock_flag", {31'h0, unlocked}, 32'd1);
    press(1'b1, 1'b0, 1'b0, 4'h5, 1);
    check_idle_buf("unl_enter");
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("relock_state", {30'h0, state}, 32'd2);
    check("relock_flag", {31'h0, unlocked}, 32'd0);

    // ---------------- set + change together in LOCKED ----------------
    enter_code(16'h1234);
    press(1'b0, 1'b1, 1'b1, 4'h0, 1);
    check("setchg_state", {30'h0, state}, 32'd2);
    check_idle_buf("setchg");

    // ---------------- lockout ----------------
    enter_code(16'h0000);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("fail1_state", {30'h0, state}, 32'd2);
    enter_code(16'h0000);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("fail2_state", {30'h0, state}, 32'd2);
    enter_code(16'h0000);
    @(posedge clock); #1;
    set_button = 1'b1;
    @(posedge clock); #1;         // edge k
    set_button = 1'b0;
    @(posedge clock); #1;         // edge k+1
    check("fail3_k1_state", {30'h0, state}, 32'd2);
    @(posedge clock); #1;         // edge k+2
    check("lockout_state", {30'h0, state}, 32'd3);
    check("lockout_flag", {31'h0, lockout}, 32'd1);
    n = 0;
    while (state == 2'b11 && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
    check("lockout_len", n, 32'd20);
    check("post_lock_state", {30'h0, state}, 32'd2);
    check("post_lock_flag", {31'h0, lockout}, 32'd0);
    // fail count restarts: a single wrong attempt must not re-enter lockout
    enter_code(16'h0000);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("post_lock_fail", {30'h0, state}, 32'd2);
    enter_code(16'h1234);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("post_lock_unlock", {30'h0, state}, 32'd1);

    // ---------------- change password ----------------
    press(1'b0, 1'b0, 1'b1, 4'h0, 1);
    check("chg_state", {30'h0, state}, 32'd0);
    check("chg_unlocked", {31'h0, unlocked}, 32'd0);
    enter_code(16'hABCD);
    check("chg_buf", {16'h0, hex1, hex2, hex3, hex4}, 32'hABCD);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("newpw_state", {30'h0, state}, 32'd2);
    enter_code(16'h1234);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("oldpw_rejected", {30'h0, state}, 32'd2);
    enter_code(16'hABCD);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("newpw_unlock", {30'h0, state}, 32'd1);

    // ---------------- asynchronous reset ----------------
    press(1'b0, 1'b0, 1'b1, 4'h0, 1);
    press(1'b1, 1'b0, 1'b0, 4'h7, 1);
    check("pre_rst_hex1", {28'h0, hex1}, 32'h7);
    @(posedge clock); #3;
    reset = 1'b0;
    enter_button = 1'b1;
    #1;
    check("arst_state", {30'h0, state}, 32'd0);
    check_idle_buf("arst");
    @(posedge clock); #1;
    reset = 1'b1;                 // enter still held through release
    repeat (10) @(posedge clock);
    #1;
    check("held_through_rst", {30'h0, counter}, 32'd0);
    enter_button = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    enter_code(16'h1234);
    check("after_rst_full", {31'h0, entry_full}, 32'd1);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1);
    check("after_rst_set", {30'h0, state}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
